// File: rtl/halt_sequencer_pkg.sv
// Shared definitions for the halt sequencer: state encodings, the SYSTEM
// opcode used by the halting unit, default drain depth and control bundle.
package halt_sequencer_pkg;

  localparam int HS_STATE_W = 3;

  localparam logic [HS_STATE_W-1:0] HS_RUN        = 3'd0;
  localparam logic [HS_STATE_W-1:0] HS_DRAIN      = 3'd1;
  localparam logic [HS_STATE_W-1:0] HS_HALTED     = 3'd2;
  localparam logic [HS_STATE_W-1:0] HS_STEP_ISSUE = 3'd3;
  localparam logic [HS_STATE_W-1:0] HS_STEP_DRAIN = 3'd4;

  // ebreak lives in the SYSTEM major opcode; decoded upstream in the halting unit
  localparam logic [6:0] OPCODE_SYSTEM = 7'b1110011;

  localparam int DRAIN_CYCLES_DEF = 3;
  localparam int CNT_W_DEF        = 4;

  typedef struct packed {
    logic pc_freeze;
    logic if_flush;
  } hs_ctrl_t;

  // Pipeline control implied by a state; in RUN it follows the accept term.
  function automatic hs_ctrl_t hs_ctrl(input logic [HS_STATE_W-1:0] st,
                                       input logic accept);
    hs_ctrl_t c;
    c = '0;
    case (st)
      HS_RUN:        c = '{pc_freeze: accept, if_flush: accept};
      HS_DRAIN:      c = '{pc_freeze: 1'b1,   if_flush: 1'b1};
      HS_HALTED:     c = '{pc_freeze: 1'b1,   if_flush: 1'b0};
      HS_STEP_ISSUE: c = '{pc_freeze: 1'b0,   if_flush: 1'b0};
      HS_STEP_DRAIN: c = '{pc_freeze: 1'b1,   if_flush: 1'b1};
      default:       c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/halt_sequencer_if.sv
// Pipeline/debug handshake bundle between the halt sequencer and its neighbours.
// halt_cycles exists only when HALT_CYCLE_COUNT_EN is defined.
interface halt_sequencer_if;

  logic        halt_req;
  logic        id_valid;
  logic        flush_id;
  logic        resume_req;
  logic        step_req;
  logic        pc_freeze;
  logic        if_flush;
  logic        halted;
  logic [2:0]  state_o;
`ifdef HALT_CYCLE_COUNT_EN
  logic [31:0] halt_cycles;
`endif

  modport master (
    output halt_req,
    output id_valid,
    output flush_id,
    output resume_req,
    output step_req,
    input  pc_freeze,
    input  if_flush,
    input  halted,
    input  state_o
`ifdef HALT_CYCLE_COUNT_EN
    , input halt_cycles
`endif
  );

  modport slave (
    input  halt_req,
    input  id_valid,
    input  flush_id,
    input  resume_req,
    input  step_req,
    output pc_freeze,
    output if_flush,
    output halted,
    output state_o
`ifdef HALT_CYCLE_COUNT_EN
    , output halt_cycles
`endif
  );

endinterface

// File: rtl/halt_drain_counter.sv
// Loadable down-counter with zero flag, shared by the halt and step drain phases.
// Decrement stops at zero so the count never wraps.
module halt_drain_counter #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  input  logic             dec_i,
  output logic             zero_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/halt_sequencer.sv
// Halt / resume / single-step sequencer driving PC-enable and IF/ID flush.
// Optional HALT_CYCLE_COUNT_EN adds a saturating count of edges spent halted.
//
// state       | meaning
// ------------+------------------------------------------------------------
// RUN         | normal execution; ebreak in ID is accepted here
// DRAIN       | PC frozen, older instructions retiring before halt
// HALTED      | quiescent; waits for resume or step
// STEP_ISSUE  | one unfrozen cycle so exactly one instruction is fetched
// STEP_DRAIN  | stepped instruction and its predecessors retiring
module halt_sequencer
  import halt_sequencer_pkg::*;
#(
  parameter int DRAIN_CYCLES = DRAIN_CYCLES_DEF,
  parameter int CNT_W        = CNT_W_DEF
) (
  input  logic           clk,
  input  logic           rst,
  halt_sequencer_if.slave hs
);

  localparam logic [CNT_W-1:0] DRAIN_LOAD = CNT_W'(DRAIN_CYCLES - 1);
  // the stepped instruction must also clear ID, hence one extra cycle
  localparam logic [CNT_W-1:0] STEP_LOAD  = CNT_W'(DRAIN_CYCLES);

  logic [HS_STATE_W-1:0] state_q, state_d;
  logic                  halted_q, halted_d;
  logic                  accept;
  logic                  cnt_load;
  logic [CNT_W-1:0]      cnt_load_val;
  logic                  cnt_dec;
  logic                  cnt_zero;
  hs_ctrl_t              ctrl;

  assign accept = hs.halt_req & hs.id_valid & ~hs.flush_id;

  always_comb begin
    state_d      = state_q;
    cnt_load     = 1'b0;
    cnt_load_val = '0;
    cnt_dec      = 1'b0;
    case (state_q)
      HS_RUN: begin
        if (accept) begin
          state_d      = HS_DRAIN;
          cnt_load     = 1'b1;
          cnt_load_val = DRAIN_LOAD;
        end
      end
      HS_DRAIN, HS_STEP_DRAIN: begin
        if (cnt_zero) begin
          state_d = HS_HALTED;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      HS_HALTED: begin
        if (hs.resume_req) begin
          state_d = HS_RUN;
        end else if (hs.step_req) begin
          state_d = HS_STEP_ISSUE;
        end
      end
      HS_STEP_ISSUE: begin
        state_d      = HS_STEP_DRAIN;
        cnt_load     = 1'b1;
        cnt_load_val = STEP_LOAD;
      end
      default: state_d = HS_RUN;
    endcase
  end

  assign halted_d = (state_d == HS_HALTED);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= HS_RUN;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      halted_q <= halted_d;
    end
  end

  halt_drain_counter #(
    .CNT_W (CNT_W)
  ) u_drain_cnt (
    .clk        (clk),
    .rst        (rst),
    .load_i     (cnt_load),
    .load_val_i (cnt_load_val),
    .dec_i      (cnt_dec),
    .zero_o     (cnt_zero)
  );

  assign ctrl         = hs_ctrl(state_q, accept);
  assign hs.pc_freeze = ctrl.pc_freeze;
  assign hs.if_flush  = ctrl.if_flush;
  assign hs.halted    = halted_q;
  assign hs.state_o   = state_q;

`ifdef HALT_CYCLE_COUNT_EN
  logic [31:0] hcyc_q, hcyc_d;

  always_comb begin
    hcyc_d = hcyc_q;
    if ((state_q == HS_RUN) && accept) begin
      hcyc_d = '0;
    end else if ((state_q == HS_HALTED) && (hcyc_q != 32'hFFFF_FFFF)) begin
      hcyc_d = hcyc_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hcyc_q <= '0;
    end else begin
      hcyc_q <= hcyc_d;
    end
  end

  assign hs.halt_cycles = hcyc_q;
`endif

endmodule

// File: tb/tb_halt_sequencer.sv
// Self-checking bench for halt_sequencer against a cycle-count reference model.
// Exercises halt_cycles as well when HALT_CYCLE_COUNT_EN is defined.
module tb_halt_sequencer;
  import halt_sequencer_pkg::*;

  localparam int DC = DRAIN_CYCLES_DEF;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  halt_sequencer_if ifc();

  halt_sequencer #(.DRAIN_CYCLES(DC), .CNT_W(CNT_W_DEF)) dut (
    .clk (clk),
    .rst (rst),
    .hs  (ifc.slave)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Model: a mode plus the number of edges left before the processor is halted.
  typedef enum int {M_RUN, M_DRAIN, M_HALTED, M_STEP} mmode_t;
  mmode_t          m_mode;
  int              m_left;
  longint unsigned m_hcyc;

  task automatic model_reset();
    m_mode = M_RUN;
    m_left = 0;
    m_hcyc = 0;
  endtask

  function automatic logic [5:0] exp_vec();
    logic acc;
    acc = (m_mode == M_RUN) && ifc.halt_req && ifc.id_valid && !ifc.flush_id;
    case (m_mode)
      M_RUN:    return {3'd0, 1'b0, acc, acc};
      M_DRAIN:  return {3'd1, 1'b0, 1'b1, 1'b1};
      M_HALTED: return {3'd2, 1'b1, 1'b1, 1'b0};
      default:  return (m_left == DC + 2) ? {3'd3, 1'b0, 1'b0, 1'b0}
                                          : {3'd4, 1'b0, 1'b1, 1'b1};
    endcase
  endfunction

  function automatic logic [5:0] act_vec();
    return {ifc.state_o, ifc.halted, ifc.pc_freeze, ifc.if_flush};
  endfunction

  task automatic drive(input logic h, input logic v, input logic f,
                       input logic r, input logic s);
    @(negedge clk);
    ifc.halt_req   = h;
    ifc.id_valid   = v;
    ifc.flush_id   = f;
    ifc.resume_req = r;
    ifc.step_req   = s;
    #1;
  endtask

  task automatic advance();
    mmode_t          nm;
    int              nl;
    longint unsigned nh;
    nm = m_mode;
    nl = m_left;
    nh = m_hcyc;
    case (m_mode)
      M_RUN: if (ifc.halt_req && ifc.id_valid && !ifc.flush_id) begin
        nm = M_DRAIN;
        nl = DC;
        nh = 0;
      end
      M_DRAIN, M_STEP: begin
        nl = m_left - 1;
        if (nl == 0) nm = M_HALTED;
      end
      M_HALTED: begin
        if (nh < 64'hFFFF_FFFF) nh = nh + 1;
        if (ifc.resume_req) nm = M_RUN;
        else if (ifc.step_req) begin
          nm = M_STEP;
          nl = DC + 2;
        end
      end
      default: nm = M_RUN;
    endcase
    @(posedge clk);
    m_mode = nm;
    m_left = nl;
    m_hcyc = nh;
  endtask

  task automatic go_halted();
    drive(0, 0, 0, 1, 0);
    advance();
    drive(1, 1, 0, 0, 0);
    advance();
    repeat (DC + 1) begin
      drive(0, 0, 0, 0, 0);
      advance();
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    ifc.halt_req = 0; ifc.id_valid = 0; ifc.flush_id = 0;
    ifc.resume_req = 0; ifc.step_req = 0;
    repeat (2) @(negedge clk);
    #1;
    n_tests++;
    if (act_vec() !== 6'b000000) begin
      n_fail++;
      $display("FAIL reset_state: got %b want %b", act_vec(), 6'b000000);
    end
`ifdef HALT_CYCLE_COUNT_EN
    n_tests++;
    if (ifc.halt_cycles !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_halt_cycles: got %0d want 0", ifc.halt_cycles);
    end
`endif
    @(negedge clk);
    rst = 1'b1;
    model_reset();
  endtask

  task automatic test_squash();
    logic [2:0] pat [4] = '{3'b111, 3'b101, 3'b100, 3'b011};
    for (int i = 0; i < 4; i++) begin
      drive(pat[i][2], pat[i][1], pat[i][0], 0, 0);
      n_tests++;
      if (act_vec() !== exp_vec()) begin
        n_fail++;
        $display("FAIL squash pat %0d: got %b want %b", i, act_vec(), exp_vec());
      end
      advance();
      drive(0, 0, 0, 0, 0);
      n_tests++;
      if ({ifc.state_o, ifc.pc_freeze} !== 4'b0000) begin
        n_fail++;
        $display("FAIL squash_stay_run pat %0d: got %b want 0000", i,
                 {ifc.state_o, ifc.pc_freeze});
      end
      advance();
    end
  endtask

  task automatic test_basic_halt();
    int lat;
    lat = -1;
    for (int i = 0; i < 9; i++) begin
      drive(0, 1, 0, 0, 0);
      advance();
    end
    drive(1, 1, 0, 0, 0);
    n_tests++;
    if ({ifc.pc_freeze, ifc.if_flush} !== 2'b11) begin
      n_fail++;
      $display("FAIL halt_accept_ctrl: got %b want 11", {ifc.pc_freeze, ifc.if_flush});
    end
    advance();
    for (int i = 1; i <= 8; i++) begin
      drive(i[0], 1, 0, 0, 0);
      n_tests++;
      if (act_vec() !== exp_vec()) begin
        n_fail++;
        $display("FAIL basic_halt cyc %0d: got %b want %b", i, act_vec(), exp_vec());
      end
      if (lat < 0 && ifc.halted === 1'b1) lat = i;
      advance();
    end
    n_tests++;
    if (lat != DC + 1) begin
      n_fail++;
      $display("FAIL halt_latency: got %0d want %0d", lat, DC + 1);
    end
    n_tests++;
    if (ifc.state_o !== 3'd2) begin
      n_fail++;
      $display("FAIL halted_state: got %0d want 2", ifc.state_o);
    end
  endtask

  task automatic test_resume_priority();
    logic saw_step;
    saw_step = 1'b0;
    go_halted();
    drive(0, 0, 0, 1, 1);
    n_tests++;
    if (act_vec() !== exp_vec()) begin
      n_fail++;
      $display("FAIL resume_prio_halted: got %b want %b", act_vec(), exp_vec());
    end
    advance();
    drive(0, 0, 0, 0, 0);
    n_tests++;
    if ({ifc.state_o, ifc.halted} !== 4'b0000) begin
      n_fail++;
      $display("FAIL resume_prio_run: got %b want 0000", {ifc.state_o, ifc.halted});
    end
    for (int i = 0; i < 3; i++) begin
      if (ifc.state_o === 3'd3) saw_step = 1'b1;
      advance();
      drive(0, 0, 0, 0, 0);
    end
    advance();
    n_tests++;
    if (saw_step !== 1'b0) begin
      n_fail++;
      $display("FAIL resume_prio_no_step: got %b want 0", saw_step);
    end
  endtask

  task automatic test_single_step(input logic ebreak);
    int unfrozen, sdrain;
    unfrozen = 0;
    sdrain   = 0;
    go_halted();
    drive(0, 0, 0, 0, 1);
    advance();
    for (int i = 0; i < DC + 5; i++) begin
      drive(ebreak, 1, 0, 0, 0);
      n_tests++;
      if (act_vec() !== exp_vec()) begin
        n_fail++;
        $display("FAIL single_step eb=%0b cyc %0d: got %b want %b", ebreak, i,
                 act_vec(), exp_vec());
      end
      if (ifc.pc_freeze === 1'b0) unfrozen++;
      if (ifc.state_o === 3'd4) sdrain++;
      advance();
    end
    n_tests++;
    if (unfrozen != 1 || sdrain != DC + 1 || ifc.halted !== 1'b1) begin
      n_fail++;
      $display("FAIL step_shape eb=%0b: got unfrozen=%0d sdrain=%0d halted=%b want 1 %0d 1",
               ebreak, unfrozen, sdrain, ifc.halted, DC + 1);
    end
  endtask

  task automatic test_reset_mid_drain();
    drive(0, 0, 0, 1, 0);
    advance();
    drive(1, 1, 0, 0, 0);
    advance();
    drive(0, 0, 0, 0, 0);
    #2 rst = 1'b0;
    #1;
    n_tests++;
    if ({ifc.state_o, ifc.halted, ifc.pc_freeze} !== 5'b00000) begin
      n_fail++;
      $display("FAIL reset_mid_drain: got %b want 00000",
               {ifc.state_o, ifc.halted, ifc.pc_freeze});
    end
    model_reset();
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_random();
    for (int i = 0; i < 1500; i++) begin
      drive(($urandom % 4) == 0, ($urandom % 4) != 0, ($urandom % 6) == 0,
            ($urandom % 16) == 0, ($urandom % 8) == 0);
      n_tests++;
      if (act_vec() !== exp_vec()) begin
        n_fail++;
        $display("FAIL random cyc %0d: got %b want %b", i, act_vec(), exp_vec());
      end
`ifdef HALT_CYCLE_COUNT_EN
      n_tests++;
      if (ifc.halt_cycles !== m_hcyc[31:0]) begin
        n_fail++;
        $display("FAIL random_hcyc cyc %0d: got %0d want %0d", i, ifc.halt_cycles,
                 m_hcyc[31:0]);
      end
`endif
      advance();
    end
  endtask

`ifdef HALT_CYCLE_COUNT_EN
  task automatic test_halt_cycles();
    drive(0, 0, 0, 1, 0);
    advance();
    drive(1, 1, 0, 0, 0);
    advance();
    repeat (DC + 19) begin
      drive(0, 0, 0, 0, 0);
      advance();
    end
    drive(0, 0, 0, 1, 0);
    advance();
    for (int i = 0; i < 4; i++) begin
      drive(0, 0, 0, 0, 0);
      n_tests++;
      if (ifc.halt_cycles !== 32'd20 || ifc.halt_cycles !== m_hcyc[31:0]) begin
        n_fail++;
        $display("FAIL halt_cycles_hold %0d: got %0d want 20", i, ifc.halt_cycles);
      end
      advance();
    end
    drive(1, 1, 0, 0, 0);
    advance();
    drive(0, 0, 0, 0, 0);
    n_tests++;
    if (ifc.halt_cycles !== 32'd0) begin
      n_fail++;
      $display("FAIL halt_cycles_clear: got %0d want 0", ifc.halt_cycles);
    end
    advance();
  endtask
`endif

  initial begin
    model_reset();
    test_reset();
    test_squash();
    test_basic_halt();
    test_resume_priority();
    test_single_step(1'b0);
    test_single_step(1'b1);
    test_reset_mid_drain();
`ifdef HALT_CYCLE_COUNT_EN
    test_halt_cycles();
`endif
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: got no finish want finish");
    $fatal(1);
  end

endmodule

// File: doc/halt_sequencer.md
Name: halt_sequencer

Overview:
- Sequences processor halt, resume and single-step around the ebreak-driven halt request from the halting unit.
- On an accepted halt it freezes the PC, squashes the younger fetched instruction, and drains older instructions for a fixed count before reporting halted.
- Sits beside the hazard unit and drives the PC-enable and IF/ID flush; resume/step come from a debug or testbench control interface.

Parameters:
- DRAIN_CYCLES, 3, cycles for older instructions in EX/MEM/WB to retire after the halting instruction leaves ID (range 1..15).
- CNT_W, 4, width of the drain counter; must hold DRAIN_CYCLES+1.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- halt_req  in  1  halting-unit output; ebreak currently in ID.
- id_valid  in  1  ID stage holds a real instruction, not a bubble.
- flush_id  in  1  branch/jump flush killing the ID instruction this cycle.
- resume_req  in  1  level; leave halted state.
- step_req  in  1  level; execute exactly one instruction, then re-halt.
- pc_freeze  out  1  holds PC and IF/ID registers.
- if_flush  out  1  turns the IF/ID register into a bubble at the next edge.
- halted  out  1  registered; processor quiescent.
- state_o  out  3  current state encoding, for debug.

Behaviour:
- States: RUN=0, DRAIN=1, HALTED=2, STEP_ISSUE=3, STEP_DRAIN=4. Reset: state=RUN, cnt=0, halted=0.
- A halt is accepted when halt_req & id_valid & ~flush_id in RUN. With flush_id=1 the ebreak is squashed and no halt occurs.
- RUN:
  - pc_freeze and if_flush equal the accept term combinationally in the accept cycle, and 0 otherwise.
  - On accept: next state DRAIN, cnt <= DRAIN_CYCLES-1.
- DRAIN:
  - pc_freeze=1, if_flush=1.
  - Decrement cnt each cycle; at cnt==0 go to HALTED.
  - halt_req, resume_req and step_req are all ignored.
  - Total accept-to-halted latency is DRAIN_CYCLES+1 edges.
- HALTED:
  - halted=1 (registered, set on the entering edge), pc_freeze=1, if_flush=0.
  - resume_req=1 -> RUN. Resume has priority over step_req when both are asserted.
  - step_req=1 -> STEP_ISSUE.
  - halted clears on the leaving edge.
- STEP_ISSUE:
  - Exactly one cycle with pc_freeze=0 and if_flush=0, so one instruction is fetched.
  - Next state STEP_DRAIN, cnt <= DRAIN_CYCLES (the stepped instruction also passes ID).
- STEP_DRAIN:
  - pc_freeze=1, if_flush=1; count down as in DRAIN, then go to HALTED.
  - If the stepped instruction is itself an ebreak, its halt_req is ignored; the end state is HALTED either way.
- step_req/resume_req are levels. A step held high across re-entry to HALTED triggers another step; callers pulse it.
- The PC is already past the ebreak when the halt is accepted, so resume continues at ebreak+4.
- Reset asserted in any state returns to RUN with halted=0 immediately (asynchronous); in-flight drain is abandoned.
- Counter never wraps: decrement only while cnt!=0.

Optional Feature:
- Macro HALT_CYCLE_COUNT_EN.
- When defined:
  - Adds output halt_cycles [31:0], counting clk edges spent in HALTED.
  - Cleared on reset and on each RUN->DRAIN accept.
  - Saturates at 32'hFFFF_FFFF.
  - Holds its value while in RUN.
- When undefined: the port and counter are absent; all other behaviour is identical.

Decomposition:
- Shared defines file: state encodings (HS_RUN .. HS_STEP_DRAIN), the existing OPCODE_SYSTEM, and default DRAIN_CYCLES.
- One natural sub-module: halt_drain_counter (loadable down-counter with zero flag), reused by DRAIN and STEP_DRAIN.
- The FSM stays in halt_sequencer.

Test Plan:
- Reset mid-DRAIN: halt accepted, rst low after 1 cycle -> state=RUN, halted=0, pc_freeze=0 immediately.
- Basic halt (DRAIN_CYCLES=3): halt_req=id_valid=1 at cycle 10 -> pc_freeze/if_flush=1 in cycle 10, halted=1 after edge 14, state_o=2.
- Squashed ebreak: halt_req=1, flush_id=1 -> pc_freeze=0, state stays RUN; the same with id_valid=0 -> no halt.
- Resume priority: in HALTED drive resume_req=step_req=1 for 1 cycle -> RUN next edge, halted=0, no STEP_ISSUE visited.
- Single step: 1-cycle step_req pulse in HALTED -> exactly one cycle with pc_freeze=0, then STEP_DRAIN for 4 cycles, halted=1 again; an ebreak as the stepped instruction gives the same timing.
- HALT_CYCLE_COUNT_EN: halt, remain 20 cycles, resume -> halt_cycles=20 and holds; the next halt accept clears it to 0.
